// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, valid/ready on both sides.
module muldiv_unit #(
  parameter int unsigned N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [N_BITS-1:0] req_in0,
  input  logic [N_BITS-1:0] req_in1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_BITS-1:0] resp_data
);

  localparam int unsigned CNT_W = $clog2(N_BITS);
  localparam int unsigned ACC_W = 2 * N_BITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
  localparam logic [N_BITS-1:0] INT_MIN = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [N_BITS-1:0]  opb_q, opb_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               resp_valid_q, resp_valid_d;
  logic [N_BITS-1:0]  resp_data_q, resp_data_d;

  // Request decode: signedness, magnitudes and the divide shortcuts
  logic              req_ready_c;
  logic              accept_c;
  logic              is_div_c;
  logic              a_signed_c, b_signed_c;
  logic              a_neg_c, b_neg_c;
  logic [N_BITS-1:0] a_mag_c, b_mag_c;
  logic              div_zero_c, div_ovf_c, special_c;
  logic [N_BITS-1:0] special_val_c;

  assign req_ready_c = (state_q == S_IDLE) && !flush && !rst;
  assign accept_c    = req_valid && req_ready_c;
  assign is_div_c    = req_op[2];
  assign a_signed_c  = is_div_c ? !req_op[0] : (req_op[1:0] != 2'b11);
  assign b_signed_c  = is_div_c ? !req_op[0] : !req_op[1];
  assign a_neg_c     = a_signed_c && req_in0[N_BITS-1];
  assign b_neg_c     = b_signed_c && req_in1[N_BITS-1];
  assign a_mag_c     = a_neg_c ? -req_in0 : req_in0;
  assign b_mag_c     = b_neg_c ? -req_in1 : req_in1;
  assign div_zero_c  = is_div_c && (req_in1 == '0);
  assign div_ovf_c   = is_div_c && !req_op[0] && (req_in0 == INT_MIN) && (req_in1 == '1);
  assign special_c   = div_zero_c || div_ovf_c;
  // Divide-by-zero: quotient all ones, remainder = dividend; overflow: quotient = dividend, remainder 0
  assign special_val_c = div_zero_c ? (req_op[1] ? req_in0 : '1)
                                    : (req_op[1] ? '0 : req_in0);

  assign req_ready  = req_ready_c;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  // Register all state; synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      acc_q        <= '0;
      opb_q        <= '0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      opb_q        <= opb_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Next-state: flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) state_d = special_c ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath step and result formatting
  logic [N_BITS:0]   mul_sum;
  logic [ACC_W-1:0]  mul_next;
  logic [N_BITS:0]   rem_sh;
  logic [N_BITS:0]   diff;
  logic [ACC_W-1:0]  div_next;
  logic [ACC_W-1:0]  step_next;
  logic [ACC_W-1:0]  product;
  logic [N_BITS-1:0] quo, rem;
  logic [N_BITS-1:0] result;

  // Outputs and datapath registers
  always_comb begin
    op_d         = op_q;
    acc_d        = acc_q;
    opb_d        = opb_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    // Multiply: add multiplicand to upper half when the multiplier LSB is set, then shift right
    mul_sum  = {1'b0, acc_q[ACC_W-1:N_BITS]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[N_BITS-1:1]};

    // Divide: shift next dividend bit into the remainder and try subtracting the divisor
    rem_sh   = acc_q[ACC_W-1:N_BITS-1];
    diff     = rem_sh - {1'b0, opb_q};
    div_next = diff[N_BITS] ? {rem_sh[N_BITS-1:0], acc_q[N_BITS-2:0], 1'b0}
                            : {diff[N_BITS-1:0],   acc_q[N_BITS-2:0], 1'b1};

    step_next = op_q[2] ? div_next : mul_next;
    product   = qneg_q ? -step_next : step_next;
    quo       = step_next[N_BITS-1:0];
    rem       = step_next[ACC_W-1:N_BITS];

    unique case (op_q)
      3'b000:                 result = product[N_BITS-1:0];
      3'b001, 3'b010, 3'b011: result = product[ACC_W-1:N_BITS];
      3'b100, 3'b101:         result = qneg_q ? -quo : quo;
      default:                result = rneg_q ? -rem : rem;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d   = req_op;
          cnt_d  = '0;
          qneg_d = a_neg_c ^ b_neg_c;
          rneg_d = a_neg_c;
          if (is_div_c) begin
            acc_d = {{N_BITS{1'b0}}, a_mag_c};
            opb_d = b_mag_c;
          end else begin
            acc_d = {{N_BITS{1'b0}}, b_mag_c};
            opb_d = a_mag_c;
          end
          if (special_c) begin
            resp_valid_d = 1'b1;
            resp_data_d  = special_val_c;
          end
        end
      end
      S_CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          resp_data_d  = result;
        end
      end
      S_DONE: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase

    if (flush) begin
      resp_valid_d = 1'b0;
      cnt_d        = '0;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed table, random ops against an arithmetic model,
// and hand-written backpressure / flush / reset sequences.
module tb_muldiv_unit;

  localparam int unsigned N = 32;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_in0;
  logic [31:0] req_in1;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  muldiv_unit #(.N_BITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_in0    (req_in0),
    .req_in1    (req_in1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    longint      ps;
    logic [31:0] r;
    pu = 64'd0;
    ps = 0;
    r  = 32'd0;
    case (op)
      3'd0: begin pu = {32'd0, a} * {32'd0, b}; r = pu[31:0]; end
      3'd1: begin ps = longint'($signed(a)) * longint'($signed(b)); pu = 64'(ps); r = pu[63:32]; end
      3'd2: begin ps = longint'($signed(a)) * longint'({32'd0, b}); pu = 64'(ps); r = pu[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == MIN32 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'($signed(a) / $signed(b));
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == MIN32 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'($signed(a) % $signed(b));
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'd0 || (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF))) return 1;
    return N + 1;
  endfunction

  // One request/response transaction; hold = cycles resp_ready stays low in DONE
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] data, output int lat);
    int w;
    logic [31:0] held;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_in0 = a; req_in1 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_in0 = $urandom; req_in1 = $urandom;
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    data = resp_data;
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_data", resp_data, held);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
    chk("valid_after_hs", {31'd0, resp_valid}, 32'd0);
  endtask

  // Watch resp_valid for a number of cycles and return how many cycles it was high
  task automatic watch_idle(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] d;
    int          lat;
    int          seen;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};
    vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[9]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[10] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    vecs[11] = '{3'd4, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1};
    vecs[13] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_in0 = 32'd0; req_in1 = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, d, lat);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Randomized ops with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = MIN32; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3: begin a = -32'($urandom_range(0, 200)); b = $urandom_range(1, 20); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      do_op(op, a, b, $urandom_range(0, 2), d, lat);
      chk($sformatf("rnd%0d_op%0d_data", i, op), d, model(op, a, b));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat(op, a, b)));
    end

    // Backpressure: 5 cycles with resp_ready low, then back-to-back ops
    do_op(3'd0, 32'h0000_1234, 32'h0000_0010, 5, d, lat);
    chk("bp_data", d, 32'h0001_2340);
    do_op(3'd5, 32'h0000_0064, 32'h0000_0007, 0, d, lat);
    chk("b2b_divu", d, 32'h0000_000E);
    do_op(3'd4, 32'h0000_0064, 32'h0000_0000, 3, d, lat);
    chk("bp_special_data", d, 32'hFFFF_FFFF);

    // Flush on the 10th CALC cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_in0 = 32'd9; req_in1 = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_req_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready_next", {31'd0, req_ready}, 32'd1);
    watch_idle(40, seen);
    chk("flush_no_resp", 32'(seen), 32'd0);
    do_op(3'd3, 32'd2, 32'd3, 0, d, lat);
    chk("post_flush_mulhu", d, 32'd0);
    chk("post_flush_lat", 32'(lat), 32'd33);

    // Reset on the 10th CALC cycle (resp_data nonzero beforehand)
    do_op(3'd0, 32'd5, 32'd6, 0, d, lat);
    chk("pre_rst_data", d, 32'd30);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; req_in0 = 32'd9; req_in1 = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_data", resp_data, 32'd0);
    watch_idle(40, seen);
    chk("rst_mid_no_resp", 32'(seen), 32'd0);

    // flush together with req_valid in IDLE: request not taken
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd5; req_in0 = 32'd5; req_in1 = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    watch_idle(5, seen);
    chk("flush_req_not_taken", 32'(seen), 32'd0);

    // flush with resp_ready in DONE: result dropped, unit back to idle
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; req_in0 = 32'd8; req_in1 = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("done_valid", {31'd0, resp_valid}, 32'd1);
    chk("done_data", resp_data, 32'd8);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    chk("flush_done_valid", {31'd0, resp_valid}, 32'd0);
    chk("flush_done_ready", {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
